inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1C00_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port aclk, input, 1, clock; reset aresetn, synchronous, active-low; clock aclk.
REQ-003 The block SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port redirect_valid, input, 1, branch/exception redirect request.
REQ-005 The block SHALL have port redirect_pc, input, 32, redirect target.
REQ-006 The block SHALL have port inst_req, output, 1, instruction bus request.
REQ-007 The block SHALL have port inst_addr, output, 32, request address.
REQ-008 The block SHALL have port inst_addr_ok, input, 1, address accepted.
REQ-009 The block SHALL have port inst_data_ok, input, 1, read data returned.
REQ-010 The block SHALL have port inst_rdata, input, 32, returned instruction.
REQ-011 The block SHALL have port allow_in, input, 1, downstream pipeline register can accept.
REQ-012 The block SHALL have port valid_out, output, 1, fetched instruction valid.
REQ-013 The block SHALL have port pc_out, output, 32, PC of inst_out.
REQ-014 The block SHALL have port inst_out, output, 32, fetched instruction.
REQ-015 The block SHALL have port adef_out, output, 1, fetch-address exception flag accompanying valid_out.

Function
REQ-016 The FSM SHALL have states REQ (inst_req=1), WAIT (awaiting data_ok) and HOLD (instruction buffered, valid_out=1).
REQ-017 Only one request SHALL be outstanding at a time; inst_req SHALL be 1 only in REQ, with inst_addr=pc held stable until inst_addr_ok.
REQ-018 REQ with inst_addr_ok=1 SHALL go to WAIT the next cycle.
REQ-019 WAIT with inst_data_ok=1 and discard=0 SHALL capture inst_rdata/pc into the output buffer and go to HOLD; valid_out rises the cycle after data_ok.
REQ-020 HOLD with allow_in=1 SHALL set pc<=pc+4 (mod 2^32) and go to REQ; valid_out drops the next cycle.
REQ-021 Redirect in HOLD SHALL drop the buffered instruction, set pc<=redirect_pc and go to REQ; redirect wins over simultaneous allow_in.
REQ-022 Redirect in WAIT without data_ok SHALL set pc<=redirect_pc and set a discard flag; the next data_ok SHALL be dropped, clear discard and go to REQ.
REQ-023 Redirect in WAIT coincident with data_ok SHALL drop that data and go to REQ with pc<=redirect_pc, leaving discard=0.
REQ-024 Redirect in REQ coincident with addr_ok SHALL go to WAIT with discard=1 and pc<=redirect_pc.
REQ-025 Redirect in REQ without addr_ok SHALL latch redirect_pc as pending and keep the current address on the bus until addr_ok, then go to WAIT with discard=1 and pc<=pending.
REQ-026 A later redirect SHALL overwrite any pending target.

Reset
REQ-027 aresetn=0 at a clock edge SHALL force state REQ, pc=RESET_PC, discard=0, pending cleared, valid_out=0, pc_out=0, inst_out=0, adef_out=0; inst_req SHALL be 1 from the first cycle after reset is released.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; no data_ok is expected after reset.

Configuration
REQ-029 With FETCH_ADEF_CHECK_EN defined, a pc with pc[1:0]!=0 in REQ SHALL issue no request and go directly to HOLD with inst_out=0 and adef_out=1, holding (ignoring allow_in) until a redirect.
REQ-030 Without FETCH_ADEF_CHECK_EN, adef_out SHALL be tied 0 and inst_addr[1:0] forced to 0.

Verification
REQ-031 Reset release, addr_ok=1 immediately, data_ok 1 cycle later with rdata=0x02800C0C, allow_in=1 -> inst_addr=0x1C000000; valid_out=1, pc_out=0x1C000000, inst_out=0x02800C0C; next inst_addr=0x1C000004.
REQ-032 allow_in=0 for 5 cycles in HOLD -> valid_out/inst_out/pc_out stable, inst_req=0 throughout.
REQ-033 Redirect to 0x1C000100 in WAIT, then data_ok with rdata=0xDEADBEEF -> data dropped, valid_out stays 0; next request addr=0x1C000100.
REQ-034 Redirect to 0x1C000200 in HOLD together with allow_in=1 -> valid_out=0 next cycle; next inst_addr=0x1C000200.
REQ-035 FETCH_ADEF_CHECK_EN defined, redirect to 0x1C000002 -> inst_req=0, valid_out=1, adef_out=1, pc_out=0x1C000002 until the next redirect.
REQ-036 aresetn=0 asserted while in WAIT -> all outputs 0 next cycle; inst_addr=0x1C000000 after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding request, one-entry output buffer, redirect/discard handling.
// Latency: valid_out one cycle after data_ok; backpressure holds the buffer while allow_in=0.
// Optional FETCH_ADEF_CHECK_EN: misaligned pc raises adef_out instead of issuing a request.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        allow_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        adef_out
);

`ifdef FETCH_ADEF_CHECK_EN
    localparam bit ADEF_EN = 1'b1;
`else
    localparam bit ADEF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend;
    logic        discard;
    logic        run;
    logic        adef_q;
    logic        misaligned;

    assign misaligned = ADEF_EN && (pc[1:0] != 2'b00);
    // run keeps the bus quiet during the reset cycle itself
    assign inst_req   = run && (state == S_REQ) && !misaligned;
    assign inst_addr  = !run ? 32'd0 : (ADEF_EN ? pc : {pc[31:2], 2'b00});
    assign adef_out   = ADEF_EN ? adef_q : 1'b0;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_pc   <= 32'd0;
            discard   <= 1'b0;
            run       <= 1'b0;
            valid_out <= 1'b0;
            pc_out    <= 32'd0;
            inst_out  <= 32'd0;
            adef_q    <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                S_REQ: begin
                    if (run) begin
                        if (misaligned) begin
                            pend <= 1'b0;
                            if (redirect_valid) begin
                                pc <= redirect_pc;
                            end else begin
                                state     <= S_HOLD;
                                valid_out <= 1'b1;
                                pc_out    <= pc;
                                inst_out  <= 32'd0;
                                adef_q    <= 1'b1;
                            end
                        end else if (inst_addr_ok) begin
                            state <= S_WAIT;
                            pend  <= 1'b0;
                            // the accepted address is already stale if a redirect arrived
                            if (redirect_valid) begin
                                pc      <= redirect_pc;
                                discard <= 1'b1;
                            end else if (pend) begin
                                pc      <= pend_pc;
                                discard <= 1'b1;
                            end
                        end else if (redirect_valid) begin
                            pend    <= 1'b1;
                            pend_pc <= redirect_pc;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        discard <= 1'b0;
                        if (redirect_valid) begin
                            pc    <= redirect_pc;
                            state <= S_REQ;
                        end else if (discard) begin
                            state <= S_REQ;
                        end else begin
                            state     <= S_HOLD;
                            valid_out <= 1'b1;
                            pc_out    <= pc;
                            inst_out  <= inst_rdata;
                            adef_q    <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        pc      <= redirect_pc;
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        state     <= S_REQ;
                        valid_out <= 1'b0;
                        adef_q    <= 1'b0;
                    end else if (allow_in && !adef_q) begin
                        pc        <= pc + 32'd4;
                        state     <= S_REQ;
                        valid_out <= 1'b0;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: transaction-level model checked every cycle plus literal checks.
module tb_inst_fetch;

`ifdef FETCH_ADEF_CHECK_EN
    localparam bit ADEF_EN = 1'b1;
`else
    localparam bit ADEF_EN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        allow_in = 1'b0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        adef_out;

    int vectors = 0;
    int miscompares = 0;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .allow_in(allow_in), .valid_out(valid_out), .pc_out(pc_out),
        .inst_out(inst_out), .adef_out(adef_out)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural fetch pc, whether a bus read is in flight and stale,
    // a queued redirect target, and the delivered instruction (if any).
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetched_t;

    fetched_t    held[$];
    logic [31:0] tgt[$];
    logic        m_live = 1'b0;
    logic        in_flight = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_fpc = RST_PC;

    function automatic logic fpc_misaligned();
        return ADEF_EN && (m_fpc[1:0] != 2'b00);
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_live = 1'b0; m_fpc = RST_PC; m_stale = 1'b0; in_flight = 1'b0;
            tgt.delete(); held.delete();
        end else if (!m_live) begin
            m_live = 1'b1;
        end else if (held.size() != 0) begin
            if (redirect_valid) begin
                held.delete(); m_fpc = redirect_pc;
            end else if (allow_in && !held[0].adef) begin
                held.delete(); m_fpc = m_fpc + 32'd4;
            end
        end else if (in_flight) begin
            if (inst_data_ok) begin
                in_flight = 1'b0;
                if (redirect_valid) m_fpc = redirect_pc;
                else if (!m_stale) held.push_back('{m_fpc, inst_rdata, 1'b0});
                m_stale = 1'b0;
            end else if (redirect_valid) begin
                m_fpc = redirect_pc; m_stale = 1'b1;
            end
        end else if (fpc_misaligned()) begin
            if (redirect_valid) m_fpc = redirect_pc;
            else held.push_back('{m_fpc, 32'd0, 1'b1});
            tgt.delete();
        end else if (inst_addr_ok) begin
            in_flight = 1'b1;
            if (redirect_valid) begin
                m_fpc = redirect_pc; m_stale = 1'b1;
            end else if (tgt.size() != 0) begin
                m_fpc = tgt[0]; m_stale = 1'b1;
            end
            tgt.delete();
        end else if (redirect_valid) begin
            tgt.delete(); tgt.push_back(redirect_pc);
        end
    end

    always @(negedge aclk) begin
        logic exp_req;
        exp_req = m_live && !in_flight && (held.size() == 0) && !fpc_misaligned();
        chk("m_inst_req", inst_req, exp_req);
        if (exp_req) chk("m_inst_addr", inst_addr, ADEF_EN ? m_fpc : {m_fpc[31:2], 2'b00});
        chk("m_valid_out", valid_out, held.size() != 0);
        chk("m_adef_out", adef_out, (held.size() != 0) ? held[0].adef : 1'b0);
        if (held.size() != 0) begin
            chk("m_pc_out", pc_out, held[0].pc);
            chk("m_inst_out", inst_out, held[0].inst);
        end
        if (!m_live) begin
            chk("m_rst_addr", inst_addr, 32'd0);
            chk("m_rst_pc_out", pc_out, 32'd0);
            chk("m_rst_inst_out", inst_out, 32'd0);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic fetch_ok(input logic [31:0] data);
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = data; step(); inst_data_ok = 1'b0;
    endtask

    task automatic accept();
        allow_in = 1'b1; step(); allow_in = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_req"}, inst_req, 1'b0);
        chk({tag, "_addr"}, inst_addr, 32'd0);
        chk({tag, "_valid"}, valid_out, 1'b0);
        chk({tag, "_pc_out"}, pc_out, 32'd0);
        chk({tag, "_inst_out"}, inst_out, 32'd0);
        chk({tag, "_adef"}, adef_out, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        all_zero("rst");
        aresetn = 1'b1; step();
        chk("first_req", inst_req, 1'b1);
        chk("first_addr", inst_addr, 32'h1C00_0000);

        // Basic fetch and hold under backpressure
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        chk("wait_no_req", inst_req, 1'b0);
        inst_data_ok = 1'b1; inst_rdata = 32'h0280_0C0C; step(); inst_data_ok = 1'b0;
        chk("f1_valid", valid_out, 1'b1);
        chk("f1_pc", pc_out, 32'h1C00_0000);
        chk("f1_inst", inst_out, 32'h0280_0C0C);
        repeat (5) step();
        chk("hold_valid", valid_out, 1'b1);
        chk("hold_inst", inst_out, 32'h0280_0C0C);
        chk("hold_req", inst_req, 1'b0);
        accept();
        chk("adv_valid", valid_out, 1'b0);
        chk("adv_addr", inst_addr, 32'h1C00_0004);

        // Redirect while waiting: returned data dropped
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0100; step(); redirect_valid = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; step(); inst_data_ok = 1'b0;
        chk("drop_valid", valid_out, 1'b0);
        chk("drop_addr", inst_addr, 32'h1C00_0100);

        // Redirect in HOLD beats allow_in
        fetch_ok(32'h1111_1111);
        chk("r100_pc", pc_out, 32'h1C00_0100);
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0200; allow_in = 1'b1; step();
        redirect_valid = 1'b0; allow_in = 1'b0;
        chk("hold_redir_valid", valid_out, 1'b0);
        chk("hold_redir_addr", inst_addr, 32'h1C00_0200);

        // Redirect coincident with data_ok leaves no discard behind
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h2222_2222;
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0300; step();
        inst_data_ok = 1'b0; redirect_valid = 1'b0;
        chk("coinc_addr", inst_addr, 32'h1C00_0300);
        fetch_ok(32'h3333_3333);
        chk("coinc_next_valid", valid_out, 1'b1);
        chk("coinc_next_pc", pc_out, 32'h1C00_0300);
        accept();

        // Pending redirect before addr_ok, overwritten by a later one
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0400; step();
        chk("pend_addr_kept", inst_addr, 32'h1C00_0304);
        redirect_pc = 32'h1C00_0500; step(); redirect_valid = 1'b0;
        fetch_ok(32'h5555_5555);
        chk("pend_drop_valid", valid_out, 1'b0);
        chk("pend_addr", inst_addr, 32'h1C00_0500);
        fetch_ok(32'h6666_6666);
        chk("pend_pc_out", pc_out, 32'h1C00_0500);
        accept();

        // Redirect coincident with addr_ok
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0600; inst_addr_ok = 1'b1; step();
        redirect_valid = 1'b0; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h7777_7777; step(); inst_data_ok = 1'b0;
        chk("ra_valid", valid_out, 1'b0);
        chk("ra_addr", inst_addr, 32'h1C00_0600);

        // Misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0002; inst_addr_ok = 1'b1; step();
        redirect_valid = 1'b0; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; step(); inst_data_ok = 1'b0;
`ifdef FETCH_ADEF_CHECK_EN
        chk("adef_noreq", inst_req, 1'b0);
        step();
        allow_in = 1'b1; step(); step(); allow_in = 1'b0;
        chk("adef_valid", valid_out, 1'b1);
        chk("adef_flag", adef_out, 1'b1);
        chk("adef_pc", pc_out, 32'h1C00_0002);
        chk("adef_inst", inst_out, 32'd0);
        chk("adef_req", inst_req, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0800; step(); redirect_valid = 1'b0;
        chk("adef_clear", adef_out, 1'b0);
`else
        chk("align_addr", inst_addr, 32'h1C00_0000);
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0800; inst_addr_ok = 1'b1; step();
        redirect_valid = 1'b0; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; step(); inst_data_ok = 1'b0;
`endif
        chk("r800_addr", inst_addr, 32'h1C00_0800);

        // Reset while waiting abandons the request
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        aresetn = 1'b0; step();
        all_zero("midrst");
        aresetn = 1'b1; step();
        chk("rel_req", inst_req, 1'b1);
        chk("rel_addr", inst_addr, 32'h1C00_0000);
        fetch_ok(32'h9999_9999);
        chk("rel_pc", pc_out, 32'h1C00_0000);
        chk("rel_inst", inst_out, 32'h9999_9999);
        accept();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
